// File: rtl/ml_score_pkg.sv
// Shared definitions for the driver-behaviour scoring engine:
// FSM state encoding, accumulator width rule and the score clamp helper.
package ml_score_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MAC  = 2'd1;
  localparam state_t ST_OUT  = 2'd2;

  // Widest accumulator the clamp helper can take without losing sign.
  localparam int MAX_ACC_W = 64;

  function automatic int accWidthMin(input int dw, input int ww, input int nFeat);
    return dw + ww + 2 + $clog2(nFeat + 1);
  endfunction

  function automatic logic [63:0] clampScore(input logic signed [63:0] acc,
                                             input int scoreW);
    logic signed [63:0] maxVal;
    maxVal = (64'sd1 <<< scoreW) - 64'sd1;
    if (acc < 0)
      return '0;
    else if (acc > maxVal)
      return $unsigned(maxVal);
    else
      return $unsigned(acc);
  endfunction

endpackage

// File: rtl/ml_mac_unit.sv
// Combinational multiply-add step: extends one feature by its signedness,
// multiplies by a signed weight and adds the product into the accumulator.
module ml_mac_unit #(
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int ACC_W = 24
) (
  input  logic signed [ACC_W-1:0] i_accIn,
  input  logic        [DW-1:0]    i_feature,
  input  logic                    i_isSigned,
  input  logic signed [WW-1:0]    i_weight,
  output logic signed [ACC_W-1:0] o_accOut
);

  logic signed [DW:0]    w_featExt;
  logic signed [DW+WW:0] w_product;

  assign w_featExt = {i_isSigned & i_feature[DW-1], i_feature};
  assign w_product = (DW+WW+1)'(w_featExt) * (DW+WW+1)'(i_weight);
  assign o_accOut  = i_accIn + ACC_W'(w_product);

endmodule

// File: rtl/ml_score_engine.sv
// Sequential weighted-sum scorer: one MAC per cycle over N_FEAT features,
// clamps to an unsigned score and debounces a high-score alarm.
module ml_score_engine
  import ml_score_pkg::*;
#(
  parameter int                N_FEAT      = 4,
  parameter int                DW          = 8,
  parameter int                WW          = 8,
  parameter int                ACC_W       = 24,
  parameter int                SCORE_W     = 8,
  parameter logic [N_FEAT-1:0] FEAT_SIGNED = 4'b0111,
  parameter int                ALARM_TH    = 200,
  parameter int                ALARM_CNT   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_FEAT*DW-1:0]         feat,
  input  logic                         w_wr_en,
  input  logic [$clog2(N_FEAT+1)-1:0]  w_wr_addr,
  input  logic [WW-1:0]                w_wr_data,
  output logic                         out_valid,
  output logic [SCORE_W-1:0]           score,
  output logic                         alarm,
  output logic                         busy
);

  localparam int IW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int HW = $clog2(ALARM_CNT + 1);

  if (ACC_W < accWidthMin(DW, WW, N_FEAT) || ACC_W > MAX_ACC_W ||
      N_FEAT < 1 || ALARM_CNT < 1) begin : g_paramCheck
    $error("ml_score_engine: illegal parameter combination (ACC_W, N_FEAT or ALARM_CNT)");
  end

  state_t                   r_state;
  logic [IW-1:0]            r_idx;
  logic [N_FEAT*DW-1:0]     r_feat;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [WW-1:0]     r_weight [N_FEAT];
  logic signed [WW-1:0]     r_bias;
  logic [SCORE_W-1:0]       r_score;
  logic                     r_outValid;
  logic                     r_alarm;
  logic [HW-1:0]            r_hitCnt;

  logic                     w_start;
  logic                     w_wrOk;
  logic                     w_wrBias;
  logic signed [WW-1:0]     w_biasSrc;
  logic [DW-1:0]            w_featSel;
  logic signed [ACC_W-1:0]  w_accNext;
  logic [SCORE_W-1:0]       w_clamp;
  logic                     w_hit;
  logic [HW-1:0]            w_hitNext;
  logic                     w_alarmNext;

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = r_outValid;
  assign score     = r_score;
  assign alarm     = r_alarm;

  assign w_start   = in_valid && (r_state == ST_IDLE);
  assign w_wrOk    = w_wr_en && (r_state == ST_IDLE);
  assign w_wrBias  = w_wrOk && (32'(w_wr_addr) == N_FEAT);
  // A bias written in the handshake cycle must seed this inference too.
  assign w_biasSrc = w_wrBias ? $signed(w_wr_data) : r_bias;

  assign w_featSel = r_feat[32'(r_idx)*DW +: DW];
  assign w_clamp   = SCORE_W'(clampScore(64'(r_acc), SCORE_W));
  assign w_hit     = 32'(w_clamp) >= ALARM_TH;

  ml_mac_unit #(
    .DW    (DW),
    .WW    (WW),
    .ACC_W (ACC_W)
  ) u_mac (
    .i_accIn    (r_acc),
    .i_feature  (w_featSel),
    .i_isSigned (FEAT_SIGNED[r_idx]),
    .i_weight   (r_weight[r_idx]),
    .o_accOut   (w_accNext)
  );

  always_comb begin
    w_hitNext   = r_hitCnt;
    w_alarmNext = 1'b0;
    if (w_hit) begin
      if (r_hitCnt < HW'(ALARM_CNT))
        w_hitNext = r_hitCnt + HW'(1);
      w_alarmNext = (w_hitNext == HW'(ALARM_CNT));
    end else begin
      w_hitNext = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_FEAT; i++)
        r_weight[i] <= '0;
      r_bias <= '0;
    end else if (w_wrOk) begin
      if (32'(w_wr_addr) < N_FEAT)
        r_weight[w_wr_addr[IW-1:0]] <= $signed(w_wr_data);
      else if (w_wrBias)
        r_bias <= $signed(w_wr_data);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_feat     <= '0;
      r_acc      <= '0;
      r_score    <= '0;
      r_outValid <= 1'b0;
      r_alarm    <= 1'b0;
      r_hitCnt   <= '0;
    end else begin
      r_outValid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_feat  <= feat;
            r_acc   <= ACC_W'(w_biasSrc);
            r_idx   <= '0;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_acc <= w_accNext;
          r_idx <= r_idx + IW'(1);
          if (r_idx == IW'(N_FEAT - 1))
            r_state <= ST_OUT;
        end
        ST_OUT: begin
          r_score    <= w_clamp;
          r_outValid <= 1'b1;
          r_hitCnt   <= w_hitNext;
          r_alarm    <= w_alarmNext;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
